// File: rtl/host_mmio_regs.sv
// rtl/host_mmio_regs.sv - host register file, doorbell launch and command completion tracker
module host_mmio_regs #(
  parameter int HOST_DW      = 32,
  parameter int ADDR_W       = 16,
  parameter int ARG_W        = 32,
  parameter int BUF_W        = 256,
  parameter int CMD_READ_MEM = 2,
  parameter int STATUS_IDLE  = 0,
  parameter int STATUS_BUSY  = 1,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_wr_en,
  input  logic               host_rd_en,
  input  logic [7:0]         host_addr,
  input  logic [HOST_DW-1:0] host_wdata,
  output logic [HOST_DW-1:0] host_rdata,
  output logic               host_rvalid,
  output logic [HOST_DW-1:0] cmd_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [ARG_W-1:0]   arg_out,
  output logic [BUF_W-1:0]   mmvr_out,
  output logic               doorbell_pulse,
  input  logic [HOST_DW-1:0] status_in,
  input  logic [BUF_W-1:0]   mem_rdata
);

  localparam int NW  = BUF_W / HOST_DW;
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW  = $clog2(ACK_TIMEOUT + 1);

  // The status codes must be distinguishable and the line must split into whole host words.
  if ((BUF_W % HOST_DW) != 0 || STATUS_IDLE == STATUS_BUSY) begin : g_bad_params
    $error("host_mmio_regs: inconsistent parameters");
  end

  // The read-back capture is taken on the WAIT_DONE exit edge itself, because
  // mem_rdata is only valid in the cycle status_in drops out of BUSY.
  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_read_q, is_read_d;
  logic [HOST_DW-1:0] cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ARG_W-1:0]   arg_q, arg_d;
  logic [BUF_W-1:0]   mmvr_q, mmvr_d;
  logic               err_q, err_d;
  logic               doorbell_q, doorbell_d;
  logic [HOST_DW-1:0] rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic               pending;
  logic               ctrl_busy;
  logic               is_mmvr;
  logic               is_locked_reg;
  logic [WIW-1:0]     widx;
  logic [HOST_DW-1:0] status_word;

  // Address decode and read mux; reads always see the pre-write register contents.
  always_comb begin
    pending       = (state_q != S_IDLE);
    ctrl_busy     = (status_in == HOST_DW'(STATUS_BUSY));
    is_mmvr       = (host_addr >= 8'd8) && (int'(host_addr) < 8 + NW);
    widx          = WIW'(host_addr - 8'd8);
    is_locked_reg = is_mmvr || (host_addr == 8'd0) || (host_addr == 8'd1) ||
                    (host_addr == 8'd2) || (host_addr == 8'd4);
    status_word        = '0;
    status_word[7:0]   = status_in[7:0];
    status_word[30]    = pending;
    status_word[31]    = err_q;
    rvalid_d = host_rd_en;
    rdata_d  = '0;
    if (host_rd_en) begin
      if (is_mmvr) begin
        rdata_d = mmvr_q[widx*HOST_DW +: HOST_DW];
      end else begin
        case (host_addr)
          8'd0:    rdata_d = cmd_q;
          8'd1:    rdata_d = HOST_DW'(addr_q);
          8'd2:    rdata_d = HOST_DW'(arg_q);
          8'd3:    rdata_d = status_word;
          default: rdata_d = '0;
        endcase
      end
    end
  end

  // Host writes, doorbell launch and the completion tracker; tracker error wins over a same-cycle clear.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_read_d  = is_read_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    arg_d      = arg_q;
    mmvr_d     = mmvr_q;
    err_d      = err_q;
    doorbell_d = 1'b0;

    if (host_wr_en && host_addr == 8'd3 && host_wdata[31]) begin
      err_d = 1'b0;
    end

    if (host_wr_en && is_locked_reg) begin
      if (pending) begin
        err_d = 1'b1;
      end else if (is_mmvr) begin
        mmvr_d[widx*HOST_DW +: HOST_DW] = host_wdata;
      end else begin
        case (host_addr)
          8'd0: cmd_d  = host_wdata;
          8'd1: addr_d = host_wdata[ADDR_W-1:0];
          8'd2: arg_d  = ARG_W'(host_wdata);
          default: begin
            doorbell_d = 1'b1;
            is_read_d  = (cmd_q == HOST_DW'(CMD_READ_MEM));
            cnt_d      = '0;
            state_d    = S_WAIT_ACK;
          end
        endcase
      end
    end

    case (state_q)
      S_WAIT_ACK: begin
        if (ctrl_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(ACK_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!ctrl_busy) begin
          if (is_read_q) begin
            mmvr_d = mem_rdata;
          end
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_read_q  <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      arg_q      <= '0;
      mmvr_q     <= '0;
      err_q      <= 1'b0;
      doorbell_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_read_q  <= is_read_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      arg_q      <= arg_d;
      mmvr_q     <= mmvr_d;
      err_q      <= err_d;
      doorbell_q <= doorbell_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // A reset arriving in the pulse cycle must keep the launch from reaching the controller.
  assign doorbell_pulse = doorbell_q & ~rst;
  assign host_rdata     = rdata_q;
  assign host_rvalid    = rvalid_q;
  assign cmd_out        = cmd_q;
  assign addr_out       = addr_q;
  assign arg_out        = arg_q;
  assign mmvr_out       = mmvr_q;

endmodule

// File: tb/tb_host_mmio_regs.sv
// tb/tb_host_mmio_regs.sv - scoreboard bench for host_mmio_regs with a behavioural model
module tb_host_mmio_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic         host_wr_en, host_rd_en;
  logic [7:0]   host_addr;
  logic [31:0]  host_wdata, host_rdata;
  logic         host_rvalid;
  logic [31:0]  cmd_out;
  logic [15:0]  addr_out;
  logic [31:0]  arg_out;
  logic [255:0] mmvr_out;
  logic         doorbell_pulse;
  logic [31:0]  status_in;
  logic [255:0] mem_rdata;

  always #5 clk = ~clk;

  host_mmio_regs #(
    .HOST_DW(32), .ADDR_W(16), .ARG_W(32), .BUF_W(256),
    .CMD_READ_MEM(2), .STATUS_IDLE(0), .STATUS_BUSY(1), .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_rd_en(host_rd_en),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .cmd_out(cmd_out), .addr_out(addr_out), .arg_out(arg_out), .mmvr_out(mmvr_out),
    .doorbell_pulse(doorbell_pulse), .status_in(status_in), .mem_rdata(mem_rdata)
  );

  int tests = 0;
  int fails = 0;
  bit started = 0;
  logic [31:0] exp_q[$];

  // Reference model: architectural registers plus one outstanding command described by
  // its controller scenario (busy start offset, busy length, final status, or timeout).
  logic [31:0]  m_cmd, m_arg;
  logic [15:0]  m_addr;
  logic [31:0]  m_mmvr[8];
  bit           m_err;
  bit           act, have_scen, tmo, is_rd;
  int           p_cyc, clear_at, cap_cyc, sb, sl;
  logic [31:0]  sfin;
  logic [255:0] cap_line;
  int           cyc;
  int           nb, nl;
  logic [31:0]  nfin;
  bit           ntmo;
  logic [255:0] mem_drv;
  int           pulses;

  task automatic chk(input string name, input logic [255:0] act_v, input logic [255:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  // Monitor: every read response is matched against the oldest predicted value.
  always @(negedge clk) begin
    if (started && host_rvalid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rvalid_unexpected: got rvalid=%b expected no response", host_rvalid);
      end else begin
        chk("host_rdata", host_rdata, exp_q.pop_front());
      end
    end
  end

  function automatic logic [255:0] m_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = m_mmvr[i];
    return l;
  endfunction

  function automatic logic [31:0] stat_at(int c);
    if (!have_scen || tmo) return 32'd0;
    if (c < p_cyc + sb) return 32'd0;
    if (c < p_cyc + sb + sl) return 32'd1;
    return sfin;
  endfunction

  function automatic bit m_pending();
    return act && (cyc >= p_cyc);
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] a, logic [31:0] st);
    logic [31:0] v;
    v = 32'd0;
    if (a >= 8'd8 && a <= 8'd15) v = m_mmvr[a - 8'd8];
    else if (a == 8'd0) v = m_cmd;
    else if (a == 8'd1) v = {16'd0, m_addr};
    else if (a == 8'd2) v = m_arg;
    else if (a == 8'd3) v = {m_err, m_pending(), 22'd0, st[7:0]};
    return v;
  endfunction

  task automatic model_reset();
    m_cmd = 0; m_arg = 0; m_addr = 0; m_err = 0;
    for (int i = 0; i < 8; i++) m_mmvr[i] = 0;
    act = 0; have_scen = 0; tmo = 0; is_rd = 0;
  endtask

  task automatic apply_write(logic [7:0] a, logic [31:0] d);
    if (a == 8'd3) begin
      if (d[31]) m_err = 0;
    end else if (a <= 8'd4 || (a >= 8'd8 && a <= 8'd15)) begin
      if (m_pending()) m_err = 1;
      else if (a == 8'd0) m_cmd = d;
      else if (a == 8'd1) m_addr = d[15:0];
      else if (a == 8'd2) m_arg = d;
      else if (a == 8'd4) begin
        act = 1; have_scen = 1;
        p_cyc = cyc + 1;
        tmo = ntmo; sb = nb; sl = nl; sfin = nfin;
        is_rd = (m_cmd == 32'd2);
        clear_at = tmo ? p_cyc + 4 : p_cyc + sb + sl + 1;
        cap_cyc = p_cyc + sb + sl;
      end else m_mmvr[a - 8'd8] = d;
    end
  endtask

  // One clock cycle of stimulus, checked against the model for that cycle.
  task automatic step(bit r, bit wr, bit rd, logic [7:0] a, logic [31:0] d);
    if (act && cyc == clear_at) begin
      act = 0;
      if (tmo) m_err = 1;
      else if (is_rd) for (int i = 0; i < 8; i++) m_mmvr[i] = cap_line[i*32 +: 32];
    end
    rst = r; host_wr_en = wr; host_rd_en = rd; host_addr = a; host_wdata = d;
    status_in = stat_at(cyc);
    mem_rdata = mem_drv;
    #1;
    chk("doorbell_pulse", doorbell_pulse, act && cyc == p_cyc && !r);
    if (doorbell_pulse === 1'b1) pulses++;
    chk("cmd_out", cmd_out, m_cmd);
    chk("addr_out", addr_out, m_addr);
    chk("arg_out", arg_out, m_arg);
    chk("mmvr_out", mmvr_out, m_line());
    if (rd) exp_q.push_back(model_read(a, status_in));
    if (act && !tmo && is_rd && cyc == cap_cyc) cap_line = mem_drv;
    if (r) model_reset();
    else if (wr) apply_write(a, d);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d); step(0, 1, 0, a, d); endtask
  task automatic rd(logic [7:0] a); step(0, 0, 1, a, 32'd0); endtask
  task automatic idle(int n); for (int i = 0; i < n; i++) step(0, 0, 0, 8'd0, 32'd0); endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    logic [255:0] line_a5;
    logic [255:0] line_t1;
    rst = 1; host_wr_en = 0; host_rd_en = 0; host_addr = 0; host_wdata = 0;
    status_in = 0; mem_rdata = 0; mem_drv = 0;
    model_reset();
    p_cyc = -10; clear_at = -10; cap_cyc = -10; sb = 0; sl = 1; sfin = 0; cap_line = 0;
    nb = 1; nl = 1; nfin = 0; ntmo = 0; cyc = 0; pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid", host_rvalid, 1'b0);
    chk("reset_rdata", host_rdata, 32'd0);
    chk("reset_pulse", doorbell_pulse, 1'b0);
    chk("reset_mmvr", mmvr_out, 256'd0);
    started = 1;
    rd(8'd3); rd(8'd0);

    // Write command: pulse once, controller busy for one cycle, MMVR untouched.
    wr(8'd0, 32'd1); wr(8'd1, 32'h0000_0010); wr(8'd2, 32'd0);
    for (int i = 0; i < 8; i++) wr(8'(8 + i), 32'h1111_1111 * (i + 1));
    nb = 1; nl = 1; nfin = 0; ntmo = 0; pulses = 0;
    wr(8'd4, 32'd0);
    idle(6);
    rd(8'd3);
    for (int i = 0; i < 8; i++) line_t1[i*32 +: 32] = 32'h1111_1111 * (i + 1);
    chk("t1_cmd_out", cmd_out, 32'd1);
    chk("t1_addr_out", addr_out, 16'h0010);
    chk("t1_mmvr_word7", mmvr_out[255:224], 32'h8888_8888);
    chk("t1_mmvr_unchanged", mmvr_out, line_t1);
    chk("t1_pulse_count", pulses, 1);

    // Read command: returned line lands in MMVR and reads back word by word.
    line_a5 = {8{32'hA5A5_A5A5}};
    wr(8'd0, 32'd2);
    mem_drv = line_a5;
    wr(8'd4, 32'd0);
    idle(5);
    for (int i = 0; i < 8; i++) rd(8'(8 + i));
    idle(2);
    chk("t2_mmvr_capture", mmvr_out, line_a5);
    mem_drv = 0;

    // Unrecognised command: no acknowledge within the timeout.
    wr(8'd0, 32'd7);
    ntmo = 1;
    wr(8'd4, 32'd0);
    ntmo = 0;
    idle(3);
    rd(8'd3);
    rd(8'd3);
    wr(8'd3, 32'h8000_0000);
    rd(8'd3);

    // Long run command halted after 20 busy cycles; writes and a second doorbell are refused.
    wr(8'd0, 32'd3);
    nb = 1; nl = 20; nfin = 32'd2; pulses = 0;
    wr(8'd4, 32'd0);
    idle(3);
    wr(8'd2, 32'h0000_DEAD);
    rd(8'd3);
    wr(8'd4, 32'd0);
    idle(20);
    rd(8'd3);
    rd(8'd2);
    chk("t4_pulse_count", pulses, 1);
    wr(8'd3, 32'h8000_0000);
    nfin = 0;

    // Reset in the pulse cycle suppresses the launch and clears everything.
    nb = 1; nl = 1; pulses = 0;
    wr(8'd0, 32'd1);
    wr(8'd4, 32'd0);
    step(1, 0, 0, 8'd0, 32'd0);
    idle(1);
    rd(8'd3); rd(8'd0);
    idle(2);
    chk("t6_pulse_count", pulses, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      bit w, r;
      logic [7:0] a;
      logic [31:0] d;
      ntmo = ($urandom_range(0, 3) == 0);
      nb = $urandom_range(0, 3);
      nl = $urandom_range(1, 6);
      nfin = ($urandom_range(0, 1) == 1) ? 32'd2 : 32'd0;
      mem_drv = rand_line();
      w = ($urandom_range(0, 9) < 4);
      r = ($urandom_range(0, 9) < 4);
      a = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 17));
      d = $urandom;
      if (a == 8'd0) d = 32'($urandom_range(0, 4));
      step(0, w, r, a, d);
    end

    idle(6);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
